cpu_loader: RTL and testbench

Boot sequencer for the `cpu` core. It accepts a byte stream over a valid/ready handshake and writes it into data RAM, then into instruction ROM as 16-bit words. It then releases the core from reset, runs it until `idle`, and reports completion. It owns the `rstn`/`setn` pins of `cpu`, and in hardware replaces the bench-side load_ram/load_rom/load_inst sequencing.

---
 rtl/cpu_loader.sv | 188 ++++++++++++++++++
 tb/tb_cpu_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_loader.sv
// Boot sequencer for the cpu core: streams RAM bytes and ROM words in, releases the core, runs it to idle.
// Optional run watchdog is compiled in with `define LOADER_WATCHDOG_EN.
module cpu_loader #(
    parameter int IMSB    = 15,
    parameter int PMSB    = 7,
    parameter int AMSB    = 7,
    parameter int DMSB    = 7,
    parameter int RUN_MAX = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DMSB:0]   in_data,
    output logic            ram_we,
    output logic [AMSB:0]   ram_addr,
    output logic [DMSB:0]   ram_wdata,
    output logic            rom_we,
    output logic [PMSB:0]   rom_addr,
    output logic [IMSB:0]   rom_wdata,
    output logic            cpu_rstn,
    output logic            cpu_setn,
    input  logic            cpu_idle,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [15:0]     run_cycles
);

    localparam int IW = ((AMSB > PMSB) ? AMSB : PMSB) + 1;
    localparam logic [IW-1:0] RAM_LAST = IW'((1 << (AMSB + 1)) - 1);
    localparam logic [IW-1:0] ROM_LAST = IW'((1 << (PMSB + 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_RAM = 3'd1,
        S_ROM_LO   = 3'd2,
        S_ROM_HI   = 3'd3,
        S_RELEASE  = 3'd4,
        S_RUN      = 3'd5,
        S_DRAIN    = 3'd6,
        S_FINISH   = 3'd7
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [DMSB:0] lo_byte;
    logic          phase;
    logic          timeout_flag;
    logic          accept;
    logic          idle_exit;
    logic          wd_hit;
    logic [15:0]   run_next;

    assign accept    = in_valid & in_ready;
    assign run_next  = (run_cycles == 16'hFFFF) ? run_cycles : (run_cycles + 16'd1);
    // run_cycles is still zero during the first RUN cycle, which masks idle there
    assign idle_exit = cpu_idle & (run_cycles != 16'd0);

`ifdef LOADER_WATCHDOG_EN
    assign wd_hit = (32'(run_next) >= 32'(RUN_MAX));
`else
    assign wd_hit = 1'b0;
`endif

    // Sequencer state, index and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            lo_byte      <= '0;
            phase        <= 1'b0;
            timeout_flag <= 1'b0;
            in_ready     <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            rom_we       <= 1'b0;
            rom_addr     <= '0;
            rom_wdata    <= '0;
            cpu_rstn     <= 1'b0;
            cpu_setn     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            run_cycles   <= 16'd0;
        end else begin
            ram_we  <= 1'b0;
            rom_we  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    cpu_rstn <= 1'b0;
                    cpu_setn <= 1'b0;
                    if (start) begin
                        state        <= S_LOAD_RAM;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        idx          <= '0;
                        run_cycles   <= 16'd0;
                        timeout_flag <= 1'b0;
                    end
                end
                S_LOAD_RAM: begin
                    if (accept) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= idx[AMSB:0];
                        ram_wdata <= in_data;
                        if (idx == RAM_LAST) begin
                            idx   <= '0;
                            state <= S_ROM_LO;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_ROM_LO: begin
                    if (accept) begin
                        lo_byte <= in_data;
                        state   <= S_ROM_HI;
                    end
                end
                S_ROM_HI: begin
                    if (accept) begin
                        rom_we    <= 1'b1;
                        rom_addr  <= idx[PMSB:0];
                        rom_wdata <= {in_data, lo_byte};
                        if (idx == ROM_LAST) begin
                            idx      <= '0;
                            in_ready <= 1'b0;
                            cpu_rstn <= 1'b1;
                            cpu_setn <= 1'b0;
                            phase    <= 1'b0;
                            state    <= S_RELEASE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_ROM_LO;
                        end
                    end
                end
                S_RELEASE: begin
                    if (phase) begin
                        phase    <= 1'b0;
                        cpu_setn <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        phase <= 1'b1;
                    end
                end
                S_RUN: begin
                    run_cycles <= run_next;
                    if (idle_exit || wd_hit) begin
                        cpu_setn     <= 1'b0;
                        timeout_flag <= ~idle_exit;
                        phase        <= 1'b0;
                        state        <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (phase) begin
                        phase    <= 1'b0;
                        cpu_rstn <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= timeout_flag;
                        state    <= S_FINISH;
                    end else begin
                        phase <= 1'b1;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    cpu_rstn <= 1'b0;
                    cpu_setn <= 1'b0;
                    busy     <= 1'b0;
                    phase    <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Self-checking bench for cpu_loader (AMSB=1, PMSB=1, RUN_MAX=8); expectations come from the byte-stream order.
module tb_cpu_loader;

    localparam int RUN_MAX = 8;
    localparam int RAM_N   = 4;
    localparam int TOTAL   = 12;
`ifdef LOADER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, cpu_idle;
    logic [7:0]  in_data;
    logic        ram_we, rom_we, cpu_rstn, cpu_setn, busy, done, timeout;
    logic [1:0]  ram_addr, rom_addr;
    logic [7:0]  ram_wdata;
    logic [15:0] rom_wdata, run_cycles;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] stream [TOTAL];

    cpu_loader #(.IMSB(15), .PMSB(1), .AMSB(1), .DMSB(7), .RUN_MAX(RUN_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_rstn(cpu_rstn),
        .cpu_setn(cpu_setn), .cpu_idle(cpu_idle), .busy(busy), .done(done),
        .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic fill_random;
        for (int i = 0; i < TOTAL; i++) stream[i] = 8'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; cpu_idle = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, ram_we, rom_we, ram_addr, ram_wdata, rom_addr, rom_wdata, cpu_rstn,
             cpu_setn, busy, done, timeout, run_cycles} !== 55'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h want 0", {in_ready, ram_we, rom_we, ram_addr, ram_wdata,
                     rom_addr, rom_wdata, cpu_rstn, cpu_setn, busy, done, timeout, run_cycles});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, in_ready, cpu_rstn, cpu_setn} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_no_start: got %b want 0000", {busy, in_ready, cpu_rstn, cpu_setn});
        end
    endtask

    // Pulses start, then streams bytes until 'limit' are accepted, checking each write one cycle later.
    task automatic load_stream(input int gap_mode, input int limit, input string tag);
        int sent, guard;
        bit exp_ram, exp_rom, vld, rdy, tog;
        logic [1:0] exp_ra, exp_oa;
        logic [7:0] exp_rd;
        logic [15:0] exp_od;
        sent = 0; guard = 0; exp_ram = 1'b0; exp_rom = 1'b0; tog = 1'b1;
        exp_ra = 2'd0; exp_oa = 2'd0; exp_rd = 8'd0; exp_od = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (guard < 200) begin
            vectors++;
            if (ram_we !== exp_ram) begin
                miscompares++;
                $display("FAIL %s ram_we: got %b want %b after byte %0d", tag, ram_we, exp_ram, sent);
            end
            if (exp_ram) begin
                vectors++;
                if ({ram_addr, ram_wdata} !== {exp_ra, exp_rd}) begin
                    miscompares++;
                    $display("FAIL %s ram_write: got (%0d,%h) want (%0d,%h)", tag, ram_addr, ram_wdata, exp_ra, exp_rd);
                end
            end
            vectors++;
            if (rom_we !== exp_rom) begin
                miscompares++;
                $display("FAIL %s rom_we: got %b want %b after byte %0d", tag, rom_we, exp_rom, sent);
            end
            if (exp_rom) begin
                vectors++;
                if ({rom_addr, rom_wdata} !== {exp_oa, exp_od}) begin
                    miscompares++;
                    $display("FAIL %s rom_write: got (%0d,%h) want (%0d,%h)", tag, rom_addr, rom_wdata, exp_oa, exp_od);
                end
            end
            vectors++;
            if ({in_ready, busy} !== {1'(sent < TOTAL), 1'b1}) begin
                miscompares++;
                $display("FAIL %s ready_busy: got %b%b want %b1", tag, in_ready, busy, 1'(sent < TOTAL));
            end
            if (sent >= limit) break;
            case (gap_mode)
                0:       vld = 1'b1;
                1:       vld = tog;
                default: vld = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            in_valid = vld;
            in_data  = vld ? stream[sent] : 8'($urandom);
            rdy = in_ready;
            exp_ram = 1'b0;
            exp_rom = 1'b0;
            if (vld && rdy) begin
                if (sent < RAM_N) begin
                    exp_ram = 1'b1; exp_ra = 2'(sent); exp_rd = stream[sent];
                end else if (((sent - RAM_N) % 2) == 1) begin
                    exp_rom = 1'b1; exp_oa = 2'((sent - RAM_N) / 2); exp_od = {stream[sent], stream[sent-1]};
                end
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 200) begin
            vectors++; miscompares++;
            $display("FAIL %s load_timeout: got %0d bytes want %0d", tag, sent, limit);
        end
    endtask

    task automatic check_release(input string tag);
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if ({cpu_rstn, cpu_setn} !== 2'b10) begin
                miscompares++;
                $display("FAIL %s release_pins: got %b want 10 in cycle %0d", tag, {cpu_rstn, cpu_setn}, c);
            end
            @(negedge clk);
        end
    endtask

    // Enters at the first RUN cycle; cpu_idle rises in cycle idle_from, start pulses in cycle start_at.
    task automatic run_phase(input int idle_from, input int start_at, input string tag);
        int j, exit_j;
        bit exp_to;
        j = 1; exit_j = 0; exp_to = 1'b0;
        while (exit_j == 0 && j < 300) begin
            vectors++;
            if ({cpu_rstn, cpu_setn, busy, done} !== 4'b1110) begin
                miscompares++;
                $display("FAIL %s run_pins: got %b want 1110 in run cycle %0d", tag, {cpu_rstn, cpu_setn, busy, done}, j);
            end
            vectors++;
            if (run_cycles !== 16'(j - 1)) begin
                miscompares++;
                $display("FAIL %s run_count: got %0d want %0d", tag, run_cycles, j - 1);
            end
            cpu_idle = (j >= idle_from);
            start    = (j == start_at);
            if (j >= 2 && j >= idle_from) exit_j = j;
            else if (WD && j >= RUN_MAX) begin exit_j = j; exp_to = 1'b1; end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        cpu_idle = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({cpu_rstn, cpu_setn, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL %s drain_pins: got %b want 100 in drain cycle %0d", tag, {cpu_rstn, cpu_setn, done}, d);
            end
            @(negedge clk);
        end
        vectors++;
        if ({done, timeout, cpu_rstn, cpu_setn, run_cycles} !== {1'b1, exp_to, 2'b00, 16'(exit_j)}) begin
            miscompares++;
            $display("FAIL %s finish: got done=%b to=%b pins=%b%b cycles=%0d want 1 %b 00 %0d",
                     tag, done, timeout, cpu_rstn, cpu_setn, run_cycles, exp_to, exit_j);
        end
        @(negedge clk);
        vectors++;
        if ({done, timeout, busy, run_cycles} !== {3'b000, 16'(exit_j)}) begin
            miscompares++;
            $display("FAIL %s back_idle: got done=%b to=%b busy=%b cycles=%0d want 000 %0d",
                     tag, done, timeout, busy, run_cycles, exit_j);
        end
    endtask

    task automatic test_basic_load;
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h80, 8'h02, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        load_stream(0, TOTAL, "basic");
        check_release("basic");
        run_phase(4, 0, "basic");
    endtask

    task automatic test_gapped;
        fill_random();
        load_stream(1, TOTAL, "gapped");
        check_release("gapped");
        run_phase(int'($urandom_range(2, 6)), 0, "gapped");
    endtask

    task automatic test_watchdog;
        fill_random();
        load_stream(2, TOTAL, "watchdog");
        check_release("watchdog");
        run_phase(WD ? 1000 : 101, 0, "watchdog");
    endtask

    task automatic test_mid_load_reset;
        fill_random();
        load_stream(0, 2, "midrst");
        rst = 1'b1;
        #1;
        vectors++;
        if ({ram_we, rom_we, in_ready, busy, cpu_rstn, cpu_setn, ram_addr, ram_wdata} !== 16'd0) begin
            miscompares++;
            $display("FAIL midrst async_clear: got %h want 0",
                     {ram_we, rom_we, in_ready, busy, cpu_rstn, cpu_setn, ram_addr, ram_wdata});
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({ram_we, in_ready, busy, cpu_rstn} !== 4'b0000) begin
                miscompares++;
                $display("FAIL midrst quiet: got %b want 0000 in cycle %0d", {ram_we, in_ready, busy, cpu_rstn}, c);
            end
        end
        in_valid = 1'b0;
        fill_random();
        load_stream(2, TOTAL, "reload");
        check_release("reload");
        run_phase(1, 0, "reload");
    endtask

    task automatic test_ignored_start;
        fill_random();
        load_stream(0, TOTAL, "ignstart");
        check_release("ignstart");
        run_phase(5, 3, "ignstart");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped();
        test_watchdog();
        test_mid_load_reset();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
